// File: rtl/coherence_snoop_responder_pkg.sv
// Shared types and widths for the dcache coherence snoop responder.
package coherence_snoop_responder_pkg;

    localparam int unsigned SNOOP_TAG_W = 26;
    localparam int unsigned SNOOP_IDX_W = 3;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLK_WORDS   = 2;
    localparam int unsigned NUM_WAYS    = 2;

    // dcache byte address split: tag | idx | blkoff | bytoff
    typedef struct packed {
        logic [SNOOP_TAG_W-1:0] tag;
        logic [SNOOP_IDX_W-1:0] idx;
        logic                   blkoff;
        logic [1:0]             bytoff;
    } dcachef_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB0,
        WB1,
        UPDATE,
        DONE
    } snoop_state_t;

    // Per-way MSI view of one frame: I = !valid, S = valid & !dirty, M = valid & dirty
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [SNOOP_TAG_W-1:0] tag;
    } frame_state_t;

    // Word-aligned writeback address for one word of the snooped block
    function automatic logic [WORD_W-1:0] wb_addr(input dcachef_t a, input logic blk);
        return {a.tag, a.idx, blk, 2'b00};
    endfunction

endpackage

// File: rtl/coherence_snoop_responder_if.sv
// Snoop-side bundle between the memory controller / dcache and the snoop responder.
interface coherence_snoop_responder_if #(
    parameter int unsigned SETS = 8
);
    import coherence_snoop_responder_pkg::*;

    localparam int unsigned IDX_W = $clog2(SETS);

    // controller snoop request
    logic                                       ccwait;
    logic                                       ccinv;
    logic [WORD_W-1:0]                          ccsnoopaddr;
    logic                                       dwait;

    // frame array read port and link register
    logic [NUM_WAYS-1:0][SNOOP_TAG_W-1:0]       frm_tag;
    logic [NUM_WAYS-1:0]                        frm_valid;
    logic [NUM_WAYS-1:0]                        frm_dirty;
    logic [NUM_WAYS-1:0][BLK_WORDS-1:0][WORD_W-1:0] frm_data;
    logic                                       ll_valid;
    logic [WORD_W-1:0]                          ll_addr;

    // responder outputs
    logic [IDX_W-1:0]                           snp_idx;
    logic                                       snp_busy;
    logic                                       snp_dWEN;
    logic [WORD_W-1:0]                          snp_daddr;
    logic [WORD_W-1:0]                          snp_dstore;
    logic                                       snp_ccwrite;
    logic                                       snp_cctrans;
    logic                                       upd_en;
    logic                                       upd_way;
    logic                                       upd_valid;
    logic                                       upd_dirty;
    logic                                       link_clr;

    modport master (
        output ccwait, ccinv, ccsnoopaddr, dwait,
        output frm_tag, frm_valid, frm_dirty, frm_data, ll_valid, ll_addr,
        input  snp_idx, snp_busy, snp_dWEN, snp_daddr, snp_dstore,
        input  snp_ccwrite, snp_cctrans,
        input  upd_en, upd_way, upd_valid, upd_dirty, link_clr
    );

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, dwait,
        input  frm_tag, frm_valid, frm_dirty, frm_data, ll_valid, ll_addr,
        output snp_idx, snp_busy, snp_dWEN, snp_daddr, snp_dstore,
        output snp_ccwrite, snp_cctrans,
        output upd_en, upd_way, upd_valid, upd_dirty, link_clr
    );

endinterface

// File: rtl/coherence_snoop_responder.sv
// MSI snoop responder: looks up the snooped block, writes back M data,
// downgrades/invalidates the frame and breaks the LL/SC link on invalidation.
module coherence_snoop_responder
    import coherence_snoop_responder_pkg::*;
#(
    parameter int unsigned SETS = 8,
    parameter int unsigned WAYS = 2
) (
    input  logic                          CLK,
    input  logic                          nRST,
    coherence_snoop_responder_if.slave    bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);

    snoop_state_t      state;
    snoop_state_t      next_state;

    dcachef_t          saddr;
    logic              sinv;
    logic [WAY_W-1:0]  hway;
    logic              cc_lost;

    frame_state_t      frm [NUM_WAYS];
    logic [NUM_WAYS-1:0] way_hit_c;
    logic              hit_c;
    logic              hit_dirty_c;
    logic [WAY_W-1:0]  hit_way_c;
    logic              link_match_c;

    logic              busy_c;
    logic              dwen_c;
    logic [WORD_W-1:0] daddr_c;
    logic [WORD_W-1:0] dstore_c;
    logic              ccwrite_c;
    logic              cctrans_c;
    logic              upd_en_c;
    logic [WAY_W-1:0]  upd_way_c;
    logic              upd_valid_c;
    logic              link_clr_c;

    logic              unused_bits;

    // Gather the frame array read port into per-way MSI records
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            frm[w].valid = bus.frm_valid[w];
            frm[w].dirty = bus.frm_dirty[w];
            frm[w].tag   = bus.frm_tag[w];
        end
    end

    // Tag compare against the latched snoop address; at most one way hits
    always_comb begin
        way_hit_c = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_hit_c[w] = frm[w].valid && (frm[w].tag == saddr.tag);
        end
        hit_c       = |way_hit_c;
        hit_way_c   = WAY_W'(way_hit_c[1]);
        hit_dirty_c = hit_c && frm[hit_way_c].dirty;
        link_match_c = sinv && bus.ll_valid && (bus.ll_addr[31:2] == saddr[31:2]);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Snoop capture, hit way and early-release tracking
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            saddr   <= '0;
            sinv    <= 1'b0;
            hway    <= '0;
            cc_lost <= 1'b0;
        end else begin
            if (state == IDLE && bus.ccwait) begin
                saddr   <= dcachef_t'(bus.ccsnoopaddr);
                sinv    <= bus.ccinv;
                cc_lost <= 1'b0;
            end
            if (state == LOOKUP) begin
                hway <= hit_way_c;
            end
            if ((state == WB0 || state == WB1 || state == UPDATE) && !bus.ccwait) begin
                cc_lost <= 1'b1;
            end
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.ccwait) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (!bus.ccwait)          next_state = IDLE;
                else if (hit_dirty_c)     next_state = WB0;
                else if (hit_c && sinv)   next_state = UPDATE;
                else                      next_state = DONE;
            end
            WB0: begin
                if (!bus.dwait) next_state = WB1;
            end
            WB1: begin
                if (!bus.dwait) next_state = UPDATE;
            end
            UPDATE: begin
                // a controller that already let go skips the DONE handshake
                if (cc_lost || !bus.ccwait) next_state = IDLE;
                else                        next_state = DONE;
            end
            DONE: begin
                if (!bus.ccwait) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from state and latched snoop context
    always_comb begin
        busy_c      = 1'b0;
        dwen_c      = 1'b0;
        daddr_c     = '0;
        dstore_c    = '0;
        ccwrite_c   = 1'b0;
        cctrans_c   = 1'b0;
        upd_en_c    = 1'b0;
        upd_way_c   = '0;
        upd_valid_c = 1'b0;
        link_clr_c  = 1'b0;
        case (state)
            IDLE: begin
            end
            LOOKUP: begin
                busy_c     = 1'b1;
                link_clr_c = link_match_c;
            end
            WB0: begin
                busy_c    = 1'b1;
                dwen_c    = 1'b1;
                daddr_c   = wb_addr(saddr, 1'b0);
                dstore_c  = bus.frm_data[hway][0];
                ccwrite_c = 1'b1;
                cctrans_c = 1'b1;
            end
            WB1: begin
                busy_c    = 1'b1;
                dwen_c    = 1'b1;
                daddr_c   = wb_addr(saddr, 1'b1);
                dstore_c  = bus.frm_data[hway][1];
                ccwrite_c = 1'b1;
                cctrans_c = 1'b1;
            end
            UPDATE: begin
                busy_c      = 1'b1;
                cctrans_c   = 1'b1;
                upd_en_c    = 1'b1;
                upd_way_c   = hway;
                upd_valid_c = !sinv;
            end
            DONE: begin
                busy_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.snp_idx     = IDX_W'(saddr.idx);
    assign bus.snp_busy    = busy_c;
    assign bus.snp_dWEN    = dwen_c;
    assign bus.snp_daddr   = daddr_c;
    assign bus.snp_dstore  = dstore_c;
    assign bus.snp_ccwrite = ccwrite_c;
    assign bus.snp_cctrans = cctrans_c;
    assign bus.upd_en      = upd_en_c;
    assign bus.upd_way     = upd_way_c;
    assign bus.upd_valid   = upd_valid_c;
    assign bus.upd_dirty   = 1'b0;
    assign bus.link_clr    = link_clr_c;

    // Byte offsets play no part in block-granular snooping
    assign unused_bits = ^{saddr.bytoff, bus.ll_addr[1:0]};

endmodule

// File: tb/tb_coherence_snoop_responder.sv
// Directed bench for the coherence snoop responder.
module tb_coherence_snoop_responder;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    coherence_snoop_responder_if #(.SETS(8)) bus ();

    coherence_snoop_responder #(
        .SETS (8),
        .WAYS (2)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        bus.ccwait      = 1'b0;
        bus.ccinv       = 1'b0;
        bus.ccsnoopaddr = '0;
        bus.dwait       = 1'b0;
        bus.ll_valid    = 1'b0;
        bus.ll_addr     = '0;
        // way0: S block tag 0xABC, way1: M block tag 0x1234
        bus.frm_valid   = 2'b11;
        bus.frm_dirty   = 2'b10;
        bus.frm_tag[0]  = 26'h0ABC;
        bus.frm_tag[1]  = 26'h1234;
        bus.frm_data[0][0] = 32'h1111_0000;
        bus.frm_data[0][1] = 32'h2222_0000;
        bus.frm_data[1][0] = 32'hDEAD_0001;
        bus.frm_data[1][1] = 32'hDEAD_0002;

        // reset for two edges, release with ccwait low
        step(); step();
        nrst = 1'b1;
        step();
        chk("rst_busy",    32'(bus.snp_busy),    32'd0);
        chk("rst_dwen",    32'(bus.snp_dWEN),    32'd0);
        chk("rst_daddr",   bus.snp_daddr,        32'd0);
        chk("rst_dstore",  bus.snp_dstore,       32'd0);
        chk("rst_ccwrite", 32'(bus.snp_ccwrite), 32'd0);
        chk("rst_cctrans", 32'(bus.snp_cctrans), 32'd0);
        chk("rst_upd_en",  32'(bus.upd_en),      32'd0);
        chk("rst_upd_way", 32'(bus.upd_way),     32'd0);
        chk("rst_upd_val", 32'(bus.upd_valid),   32'd0);
        chk("rst_upd_dty", 32'(bus.upd_dirty),   32'd0);
        chk("rst_linkclr", 32'(bus.link_clr),    32'd0);
        chk("rst_idx",     32'(bus.snp_idx),     32'd0);

        // M hit, no invalidate, no dwait: M -> S
        bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'h0004_8D28;
        step();   // cycle 1: LOOKUP
        chk("m_c1_busy", 32'(bus.snp_busy), 32'd1);
        chk("m_c1_idx",  32'(bus.snp_idx),  32'd5);
        chk("m_c1_dwen", 32'(bus.snp_dWEN), 32'd0);
        step();   // cycle 2: WB0
        chk("m_c2_dwen",    32'(bus.snp_dWEN),    32'd1);
        chk("m_c2_daddr",   bus.snp_daddr,        32'h0004_8D28);
        chk("m_c2_dstore",  bus.snp_dstore,       32'hDEAD_0001);
        chk("m_c2_ccwrite", 32'(bus.snp_ccwrite), 32'd1);
        chk("m_c2_cctrans", 32'(bus.snp_cctrans), 32'd1);
        step();   // cycle 3: WB1
        chk("m_c3_dwen",    32'(bus.snp_dWEN),    32'd1);
        chk("m_c3_daddr",   bus.snp_daddr,        32'h0004_8D2C);
        chk("m_c3_dstore",  bus.snp_dstore,       32'hDEAD_0002);
        chk("m_c3_ccwrite", 32'(bus.snp_ccwrite), 32'd1);
        step();   // cycle 4: UPDATE
        chk("m_c4_upd_en",  32'(bus.upd_en),      32'd1);
        chk("m_c4_upd_way", 32'(bus.upd_way),     32'd1);
        chk("m_c4_upd_val", 32'(bus.upd_valid),   32'd1);
        chk("m_c4_upd_dty", 32'(bus.upd_dirty),   32'd0);
        chk("m_c4_ccwrite", 32'(bus.snp_ccwrite), 32'd0);
        chk("m_c4_cctrans", 32'(bus.snp_cctrans), 32'd1);
        chk("m_c4_dwen",    32'(bus.snp_dWEN),    32'd0);
        step();   // cycle 5: DONE
        chk("m_c5_busy",   32'(bus.snp_busy), 32'd1);
        chk("m_c5_upd_en", 32'(bus.upd_en),   32'd0);
        bus.ccwait = 1'b0;
        step();
        chk("m_idle_busy", 32'(bus.snp_busy), 32'd0);

        // M hit with invalidate, dwait held three cycles in WB0: M -> I
        bus.ccwait = 1'b1; bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h0004_8D28;
        step();   // cycle 1
        bus.dwait = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            step();
            if (c == 5) bus.dwait = 1'b0;
            chk($sformatf("mi_c%0d_wb0_dwen", c), 32'(bus.snp_dWEN), 32'd1);
            chk($sformatf("mi_c%0d_wb0_addr", c), bus.snp_daddr, 32'h0004_8D28);
        end
        step();   // cycle 6: WB1
        chk("mi_c6_daddr",  bus.snp_daddr,  32'h0004_8D2C);
        chk("mi_c6_dstore", bus.snp_dstore, 32'hDEAD_0002);
        step();   // cycle 7: UPDATE
        chk("mi_c7_upd_en",  32'(bus.upd_en),    32'd1);
        chk("mi_c7_upd_val", 32'(bus.upd_valid), 32'd0);
        chk("mi_c7_upd_way", 32'(bus.upd_way),   32'd1);
        step();   // cycle 8: DONE
        chk("mi_c8_busy", 32'(bus.snp_busy), 32'd1);
        bus.ccwait = 1'b0;
        step();

        // clean S hit with invalidate: S -> I, no writeback
        bus.ccwait = 1'b1; bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h0002_AF10;
        step();   // cycle 1
        chk("si_c1_idx",  32'(bus.snp_idx),  32'd2);
        chk("si_c1_dwen", 32'(bus.snp_dWEN), 32'd0);
        step();   // cycle 2: UPDATE
        chk("si_c2_upd_en",  32'(bus.upd_en),      32'd1);
        chk("si_c2_upd_way", 32'(bus.upd_way),     32'd0);
        chk("si_c2_upd_val", 32'(bus.upd_valid),   32'd0);
        chk("si_c2_dwen",    32'(bus.snp_dWEN),    32'd0);
        chk("si_c2_ccwrite", 32'(bus.snp_ccwrite), 32'd0);
        chk("si_c2_cctrans", 32'(bus.snp_cctrans), 32'd1);
        bus.ccwait = 1'b0;
        step();
        chk("si_idle_busy", 32'(bus.snp_busy), 32'd0);

        // clean S hit, read snoop: stays S, nothing changes
        bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'h0002_AF10;
        step();   // cycle 1
        chk("ss_c1_busy", 32'(bus.snp_busy), 32'd1);
        step();   // cycle 2: DONE
        chk("ss_c2_busy",    32'(bus.snp_busy),    32'd1);
        chk("ss_c2_upd_en",  32'(bus.upd_en),      32'd0);
        chk("ss_c2_cctrans", 32'(bus.snp_cctrans), 32'd0);
        bus.ccwait = 1'b0;
        step();

        // miss with invalidate to the linked word: one link_clr pulse
        bus.ll_valid = 1'b1; bus.ll_addr = 32'h0010_0040;
        bus.ccwait = 1'b1; bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h0010_0040;
        step();   // cycle 1
        chk("ll_c1_linkclr", 32'(bus.link_clr), 32'd1);
        step();   // cycle 2: DONE
        chk("ll_c2_linkclr", 32'(bus.link_clr),    32'd0);
        chk("ll_c2_busy",    32'(bus.snp_busy),    32'd1);
        chk("ll_c2_upd_en",  32'(bus.upd_en),      32'd0);
        chk("ll_c2_cctrans", 32'(bus.snp_cctrans), 32'd0);
        bus.ccwait = 1'b0;
        step();

        // linked word is the neighbour: no pulse
        bus.ll_addr = 32'h0010_0044;
        bus.ccwait = 1'b1; bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h0010_0040;
        step();
        chk("ll4_c1_linkclr", 32'(bus.link_clr), 32'd0);
        step();
        chk("ll4_c2_linkclr", 32'(bus.link_clr), 32'd0);
        bus.ccwait = 1'b0; bus.ll_valid = 1'b0;
        step();

        // controller withdraws during LOOKUP: no writeback
        bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'h0004_8D28;
        step();   // cycle 1
        bus.ccwait = 1'b0;
        step();   // cycle 2
        chk("wd_c2_busy", 32'(bus.snp_busy), 32'd0);
        chk("wd_c2_dwen", 32'(bus.snp_dWEN), 32'd0);
        step();

        // reset during WB1 abandons the writeback
        bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'h0004_8D28;
        step(); step(); step();   // cycle 3: WB1
        chk("rw_c3_daddr", bus.snp_daddr, 32'h0004_8D2C);
        nrst = 1'b0; bus.ccwait = 1'b0;
        step();
        chk("rw_busy",   32'(bus.snp_busy), 32'd0);
        chk("rw_upd_en", 32'(bus.upd_en),   32'd0);
        chk("rw_idx",    32'(bus.snp_idx),  32'd0);
        nrst = 1'b1;
        step();
        chk("rw_post_upd_en", 32'(bus.upd_en), 32'd0);

        // fresh snoop after reset completes normally
        bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'h0004_8D28;
        step(); step();   // cycle 2: WB0
        chk("fr_c2_daddr",  bus.snp_daddr,  32'h0004_8D28);
        chk("fr_c2_dstore", bus.snp_dstore, 32'hDEAD_0001);
        step();   // cycle 3: WB1
        chk("fr_c3_daddr",  bus.snp_daddr,  32'h0004_8D2C);
        step();   // cycle 4: UPDATE
        chk("fr_c4_upd_en",  32'(bus.upd_en),    32'd1);
        chk("fr_c4_upd_val", 32'(bus.upd_valid), 32'd1);
        bus.ccwait = 1'b0;
        step();   // controller already gone: straight to IDLE
        chk("fr_c5_busy", 32'(bus.snp_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coherence_snoop_responder.md
# coherence_snoop_responder

Cache-side responder for the coherence half of the cache/memory-controller interface. It sits inside each dcache, watches `ccwait`/`ccinv`/`ccsnoopaddr` from the memory controller, looks up the snooped block in the dcache frame array, and does what MSI requires:
- drives `ccwrite`/`cctrans`;
- writes back a Modified block over the dcache's `dWEN`/`daddr`/`dstore` lines;
- downgrades or invalidates the frame.

It also breaks the local LL/SC link on an invalidating snoop to the linked word.

## Interface
Parameters:
- `SETS`, 8: dcache sets; index width `IDX_W = $clog2(SETS)`.
- `WAYS`, 2: associativity. Fixed at 2; the way select is 1 bit.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `ccwait`  in  1  controller requests a snoop; held high for the whole snoop.
- `ccinv`  in  1  snoop is invalidating (remote write miss). Sampled with `ccwait`.
- `ccsnoopaddr`  in  32  snooped byte address, in `dcachef_t` layout.
- `dwait`  in  1  memory controller busy on this cache's data port.
- `frm_tag`  in  2x26  tags of both ways at `snp_idx`.
- `frm_valid`  in  2  valid bits of both ways.
- `frm_dirty`  in  2  dirty (M) bits of both ways.
- `frm_data`  in  2x2x32  block data, [way][word].
- `ll_valid`  in  1  link register valid.
- `ll_addr`  in  32  linked address.
- `snp_idx`  out  IDX_W  frame-array read index.
- `snp_busy`  out  1  snoop in progress; the dcache stalls the CPU and yields the data port.
- `snp_dWEN`  out  1  writeback write enable.
- `snp_daddr`  out  32  writeback address.
- `snp_dstore`  out  32  writeback data.
- `snp_ccwrite`  out  1  this cache is supplying the block (M hit).
- `snp_cctrans`  out  1  this cache's frame is changing state.
- `upd_en`  out  1  one-cycle frame state write.
- `upd_way`  out  1  way to update.
- `upd_valid`  out  1  new valid bit.
- `upd_dirty`  out  1  new dirty bit; always 0.
- `link_clr`  out  1  one-cycle pulse that clears the link register.

## Operation
Address split: tag [31:6], idx [5:3], blkoff [2], bytoff [1:0].

Hit condition: `frm_valid[w] && frm_tag[w] == tag` for either way. At most one way hits.

FSM states:
- IDLE
  - If `ccwait`: latch `ccsnoopaddr` and `ccinv` into `saddr`/`sinv`, go to LOOKUP.
- LOOKUP
  - `snp_idx` is `saddr.idx`; the frame inputs are used combinationally. Record `hway`.
  - Hit and dirty: go to WB0.
  - Hit, clean, and `sinv`: go to UPDATE.
  - Otherwise: go to DONE.
  - If `sinv && ll_valid && ll_addr[31:2]==saddr[31:2]`: pulse `link_clr`, whether or not the block hits.
- WB0
  - Drive `snp_dWEN=1`, `snp_daddr={tag,idx,1'b0,2'b00}`, `snp_dstore=frm_data[hway][0]`.
  - Stay while `dwait`; go to WB1 on the first cycle with `!dwait`.
- WB1
  - Same as WB0 with blkoff 1 and word 1.
  - On `!dwait`, go to UPDATE.
- UPDATE
  - `upd_en=1`, `upd_way=hway`, `upd_valid=!sinv`, `upd_dirty=0`. Resulting frame states: M→S, M→I, or S→I.
  - Go to DONE.
- DONE
  - Wait for `!ccwait`, then go to IDLE. A new snoop needs `ccwait` low for at least one cycle.

Output qualifiers:
- `snp_busy` is high in every state except IDLE.
- `snp_ccwrite` is high in WB0 and WB1.
- `snp_cctrans` is high in WB0, WB1 and UPDATE.

Boundary conditions:
- `ccwait` drops in LOOKUP: go to IDLE; no writeback, no update.
- `ccwait` drops in WB0, WB1 or UPDATE: the sequence runs to completion, then goes to IDLE, skipping the DONE wait.
- Snoop that hits in S without `ccinv`: no state change, `snp_cctrans` stays 0.
- Snoop miss: no outputs besides `snp_busy` and a possible `link_clr`.
- Snoop and local CPU miss in the same cycle: the snoop wins. The dcache holds its own miss FSM while `snp_busy`.

## Timing
- Reset (`nRST` low at a `CLK` edge): state goes to IDLE; `saddr`, `sinv`, `hway` are cleared; all outputs are 0, including `snp_idx`. A reset mid-writeback abandons it with no update.
- All outputs are combinational from the state register and latched values. `snp_idx` is registered (from `saddr`).
- Latencies from `ccwait` rising:
  - Miss, or S hit without `ccinv`: `snp_busy` rises at cycle 1 (LOOKUP) and the FSM is in DONE at cycle 2.
  - S→I: `upd_en` in cycle 2.
  - M hit with zero `dwait`: WB0 in cycle 2, WB1 in cycle 3, UPDATE in cycle 4.
  - Each `dwait` cycle adds one cycle.
- `link_clr` is exactly one cycle, in LOOKUP.

## Structure
- Add to `cpu_types_pkg`:
  - `snoop_state_t` enum: IDLE, LOOKUP, WB0, WB1, UPDATE, DONE.
  - `frame_state_t` struct: valid, dirty, tag.
  - `SNOOP_TAG_W = 26`.
- Reuse the existing `dcachef_t` for the address split.
- No sub-module. It is one FSM plus the latch registers.

## Test plan
- Reset held 2 cycles, then released with `ccwait=0` → every output 0, FSM in IDLE.
- Way1 valid, dirty, tag `0x1234`; snoop `0x00048D28` with `ccinv=0`, `dwait=0` →
  - writes `0x00048D28` then `0x00048D2C` with the way1 data, `ccwrite`/`cctrans` high for 2 cycles;
  - `upd_en` in cycle 4 with `upd_valid=1`, `upd_dirty=0`.
- Same as above with `ccinv=1` and `dwait` high for 3 cycles in WB0 → WB0 lasts 4 cycles, `upd_valid=0`.
- Clean S hit with `ccinv=1` → `upd_en` in cycle 2 and no `dWEN`. Same hit with `ccinv=0` → no `upd_en` and `cctrans=0`.
- Miss with `ccinv=1`, `ll_valid=1`, `ll_addr` equal to the snoop address → single `link_clr` pulse; with `ll_addr` 4 bytes off → no pulse.
- `nRST` low during WB1 → next cycle IDLE, no `upd_en`; a fresh snoop then completes normally.
